// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, the data port and the single-ported memory bus that the arbiter shares between them.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_cancel;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          i_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one outstanding memory transaction between fetch (I) and data (D) ports, D first,
// with wait-timeout abort and a cancel path that drops wrong-path fetches.
module unified_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  unified_mem_arbiter_if.master bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t          state, stateNext;
  logic   [CW-1:0] waitCnt;
  logic            cancelFlag;
  logic            issueD, issueI, ackSeen, timedOut;
  logic            fetchEnd, dataEnd, fetchKeep;
  logic   [DW-1:0] endData;

  assign bus.i_stall = bus.i_req & ~bus.i_done;
  assign bus.d_stall = bus.d_req & ~bus.d_done;

  always_comb begin
    stateNext = state;
    issueD    = 1'b0;
    issueI    = 1'b0;
    ackSeen   = 1'b0;
    timedOut  = 1'b0;
    case (state)
      // A port whose done is high this cycle is not re-issued.
      IDLE: begin
        if (bus.d_req && !bus.d_done) begin
          issueD    = 1'b1;
          stateNext = D_BUSY;
        end else if (bus.i_req && !bus.i_cancel && !bus.i_done) begin
          issueI    = 1'b1;
          stateNext = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_ack) begin
          ackSeen   = 1'b1;
          stateNext = IDLE;
        end else if (waitCnt == LAST) begin
          timedOut  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign fetchEnd  = (ackSeen | timedOut) && (state == I_BUSY);
  assign dataEnd   = (ackSeen | timedOut) && (state == D_BUSY);
  assign fetchKeep = ~cancelFlag & ~bus.i_cancel;
  assign endData   = ackSeen ? bus.mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.bus_err   <= 1'b0;
      waitCnt       <= '0;
      cancelFlag    <= 1'b0;
    end else begin
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.bus_err <= 1'b0;

      if (issueD) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
      end else if (issueI) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.i_addr;
      end

      if (state == IDLE) begin
        waitCnt    <= '0;
        cancelFlag <= 1'b0;
      end else if (ackSeen || timedOut) begin
        bus.mem_req <= 1'b0;
      end else begin
        waitCnt <= waitCnt + 1'b1;
        if (state == I_BUSY && bus.i_cancel) cancelFlag <= 1'b1;
      end

      // A cancelled fetch still finishes on the bus but reports nothing.
      if (fetchEnd && fetchKeep) begin
        bus.i_done  <= 1'b1;
        bus.bus_err <= timedOut;
        bus.i_rdata <= endData;
      end
      if (dataEnd) begin
        bus.d_done  <= 1'b1;
        bus.bus_err <= timedOut;
        if (!bus.mem_we) bus.d_rdata <= endData;
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: reset, fetch, D/I conflict, store, cancel and timeout scenarios.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFails  = 0;

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.i_cancel = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    tick(); tick();
    nChecks++;
    if ({bus.mem_req, bus.mem_we, bus.i_done, bus.d_done, bus.bus_err} !== 5'b0) begin
      nFails++; $display("FAIL reset_ctrl got %b want 00000",
                         {bus.mem_req, bus.mem_we, bus.i_done, bus.d_done, bus.bus_err});
    end
    nChecks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0) begin
      nFails++; $display("FAIL reset_data got %h want 0",
                         {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata});
    end
    reset = 1'b0;
    tick();
    // Start a fetch and reset it mid-flight.
    bus.i_req = 1; bus.i_addr = 32'h300;
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b1) begin nFails++; $display("FAIL rst_issue mem_req got %b want 1", bus.mem_req); end
    reset = 1'b1;
    #1;
    nChecks++;
    if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL rst_async mem_req got %b want 0", bus.mem_req); end
    bus.i_req = 0;
    tick();
    reset = 1'b0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h5555AAAA;
    tick();
    bus.mem_ack = 0;
    nChecks++;
    if ({bus.i_done, bus.d_done, bus.mem_req} !== 3'b0 || bus.i_rdata !== 32'h0) begin
      nFails++; $display("FAIL rst_stray_ack done/req got %b rdata %h want 000 / 0",
                         {bus.i_done, bus.d_done, bus.mem_req}, bus.i_rdata);
    end
    tick();
  endtask

  task automatic test_fetch();
    bus.i_req = 1; bus.i_addr = 32'h100;
    #1;
    nChecks++;
    if (bus.i_stall !== 1'b1) begin nFails++; $display("FAIL fetch_stall got %b want 1", bus.i_stall); end
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin
      nFails++; $display("FAIL fetch_issue req %b addr %h we %b want 1 100 0", bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    tick(); tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.i_done !== 1'b0) begin
      nFails++; $display("FAIL fetch_wait req %b done %b want 1 0", bus.mem_req, bus.i_done);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hE3A01005;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    nChecks++;
    if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'hE3A01005 || bus.mem_req !== 1'b0 || bus.i_stall !== 1'b0) begin
      nFails++; $display("FAIL fetch_done done %b rdata %h req %b stall %b want 1 e3a01005 0 0",
                         bus.i_done, bus.i_rdata, bus.mem_req, bus.i_stall);
    end
    bus.i_req = 0;
    tick();
    nChecks++;
    if (bus.i_done !== 1'b0 || bus.mem_req !== 1'b0) begin
      nFails++; $display("FAIL fetch_pulse done %b req %b want 0 0", bus.i_done, bus.mem_req);
    end
  endtask

  task automatic test_conflict();
    bus.i_req = 1; bus.i_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.i_stall !== 1'b1 || bus.d_stall !== 1'b1) begin
      nFails++; $display("FAIL conflict_d_first req %b addr %h istall %b dstall %b want 1 200 1 1",
                         bus.mem_req, bus.mem_addr, bus.i_stall, bus.d_stall);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_ack = 0;
    nChecks++;
    if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h12345678 || bus.i_stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      nFails++; $display("FAIL conflict_d_done done %b rdata %h istall %b req %b want 1 12345678 1 0",
                         bus.d_done, bus.d_rdata, bus.i_stall, bus.mem_req);
    end
    bus.d_req = 0;
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_we !== 1'b0 || bus.i_stall !== 1'b1) begin
      nFails++; $display("FAIL conflict_i_issue req %b addr %h we %b istall %b want 1 104 0 1",
                         bus.mem_req, bus.mem_addr, bus.mem_we, bus.i_stall);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack = 0;
    nChecks++;
    if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'hCAFEF00D || bus.d_done !== 1'b0) begin
      nFails++; $display("FAIL conflict_i_done done %b rdata %h ddone %b want 1 cafef00d 0",
                         bus.i_done, bus.i_rdata, bus.d_done);
    end
    bus.i_req = 0;
    tick();
  endtask

  task automatic test_store();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h44; bus.d_wdata = 32'hDEADBEEF;
    tick();
    bus.d_addr = 32'h48; bus.d_wdata = 32'h0;
    tick(); tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h44 || bus.mem_wdata !== 32'hDEADBEEF) begin
      nFails++; $display("FAIL store_stable req %b we %b addr %h wdata %h want 1 1 44 deadbeef",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF0000;
    tick();
    bus.mem_ack = 0;
    nChecks++;
    if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h12345678 || bus.bus_err !== 1'b0) begin
      nFails++; $display("FAIL store_done done %b rdata %h err %b want 1 12345678 0",
                         bus.d_done, bus.d_rdata, bus.bus_err);
    end
    bus.d_req = 0; bus.d_we = 0;
    tick();
  endtask

  task automatic test_cancel();
    // Cancel in IDLE blocks issue.
    bus.i_req = 1; bus.i_addr = 32'h108; bus.i_cancel = 1;
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL cancel_idle req %b want 0", bus.mem_req); end
    bus.i_cancel = 0;
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h108) begin
      nFails++; $display("FAIL cancel_issue req %b addr %h want 1 108", bus.mem_req, bus.mem_addr);
    end
    bus.i_cancel = 1;
    tick();
    bus.i_cancel = 0; bus.i_addr = 32'h20C;
    bus.mem_ack = 1; bus.mem_rdata = 32'h00000BAD;
    tick();
    bus.mem_ack = 0;
    nChecks++;
    if (bus.i_done !== 1'b0 || bus.i_rdata !== 32'hCAFEF00D || bus.mem_req !== 1'b0) begin
      nFails++; $display("FAIL cancel_drop done %b rdata %h req %b want 0 cafef00d 0",
                         bus.i_done, bus.i_rdata, bus.mem_req);
    end
    tick();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20C) begin
      nFails++; $display("FAIL cancel_reissue req %b addr %h want 1 20c", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h600DF00D;
    tick();
    bus.mem_ack = 0;
    nChecks++;
    if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'h600DF00D) begin
      nFails++; $display("FAIL cancel_new done %b rdata %h want 1 600df00d", bus.i_done, bus.i_rdata);
    end
    bus.i_req = 0;
    tick();
  endtask

  task automatic test_timeout();
    int reqCycles = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    tick();
    for (int k = 0; k < 40; k++) begin
      if (bus.mem_req !== 1'b1) break;
      reqCycles++;
      tick();
    end
    nChecks++;
    if (reqCycles != 16) begin nFails++; $display("FAIL timeout_len req cycles %0d want 16", reqCycles); end
    nChecks++;
    if (bus.d_done !== 1'b1 || bus.bus_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
      nFails++; $display("FAIL timeout_done done %b err %b rdata %h want 1 1 0",
                         bus.d_done, bus.bus_err, bus.d_rdata);
    end
    bus.d_req = 0;
    tick();
    nChecks++;
    if (bus.bus_err !== 1'b0 || bus.d_done !== 1'b0 || bus.mem_req !== 1'b0) begin
      nFails++; $display("FAIL timeout_pulse err %b done %b req %b want 0 0 0",
                         bus.bus_err, bus.d_done, bus.mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_cancel();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
